// File: rtl/quad_step_decoder_if.sv
// Signal bundle between the rotary-encoder front end and its consumer.
// The master side drives the raw phases and clear; the slave side (decoder) drives status.
interface quad_step_decoder_if #(
    parameter int CNT_WIDTH = 8
) ();
    logic                 encoder_a;
    logic                 encoder_b;
    logic                 clear;
    logic                 ready;
    logic                 step;
    logic                 dir;
    logic [CNT_WIDTH-1:0] position;
    logic                 err;

    modport master (
        output encoder_a, encoder_b, clear,
        input  ready, step, dir, position, err
    );

    modport slave (
        input  encoder_a, encoder_b, clear,
        output ready, step, dir, position, err
    );
endinterface

// File: rtl/quad_step_decoder.sv
// Rotary encoder front end: synchronises and debounces both phases, then decodes
// Gray-code transitions into detent steps, a direction flag and a wrapping position.
module quad_step_decoder #(
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES  = 1000,
    parameter int STEPS_PER_DETENT = 4,
    parameter int CNT_WIDTH        = 8
) (
    input logic                clk,
    input logic                rst,
    quad_step_decoder_if.slave bus
);

    localparam int INIT_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam int INIT_W      = $clog2(INIT_CYCLES + 1);
    localparam int DEB_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SUB_W       = $clog2(STEPS_PER_DETENT) + 2;

    localparam logic signed [SUB_W-1:0] SUB_MAX = SUB_W'(STEPS_PER_DETENT);
    localparam logic signed [SUB_W-1:0] SUB_MIN = -SUB_MAX;

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    typedef enum logic [1:0] {MV_NONE, MV_FWD, MV_BACK, MV_ILLEGAL} move_t;

    state_t                  state, state_next;
    logic [INIT_W-1:0]       init_cnt, init_cnt_next;
    logic [SYNC_STAGES-1:0]  sync_a, sync_b;
    logic [1:0]              ab_sync;
    logic [1:0]              filt, filt_next;
    logic [1:0]              filt_prev, filt_prev_next;
    logic [DEB_W-1:0]        deb_cnt [2];
    logic [DEB_W-1:0]        deb_cnt_next [2];
    logic signed [SUB_W-1:0] sub_cnt, sub_cnt_next;
    logic signed [SUB_W-1:0] sub_delta, sub_sum;
    logic [CNT_WIDTH-1:0]    position, position_next;
    logic                    dir, dir_next;
    logic                    err, err_next;
    logic                    step, step_next;
    logic                    ready, ready_next;
    move_t                   move;

    // AB is {A, B}; the forward sequence is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic move_t decode_move(input logic [1:0] prev, input logic [1:0] cur);
        case ({prev, cur})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: decode_move = MV_FWD;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: decode_move = MV_BACK;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: decode_move = MV_ILLEGAL;
            default:                            decode_move = MV_NONE;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], bus.encoder_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], bus.encoder_b};
        end
    end

    assign ab_sync = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
    assign move    = decode_move(filt_prev, filt);

    always_comb begin
        state_next      = state;
        init_cnt_next   = init_cnt;
        filt_next       = filt;
        filt_prev_next  = filt;
        deb_cnt_next[0] = deb_cnt[0];
        deb_cnt_next[1] = deb_cnt[1];
        sub_cnt_next    = sub_cnt;
        position_next   = position;
        dir_next        = dir;
        err_next        = err;
        step_next       = 1'b0;
        ready_next      = ready;
        sub_delta       = '0;
        sub_sum         = sub_cnt;

        case (state)
            ST_INIT: begin
                // Adopt whatever the encoder is resting on so start-up never decodes a move.
                if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
                    state_next     = ST_RUN;
                    ready_next     = 1'b1;
                    filt_next      = ab_sync;
                    filt_prev_next = ab_sync;
                end else begin
                    init_cnt_next = init_cnt + INIT_W'(1);
                end
            end

            ST_RUN: begin
                for (int i = 0; i < 2; i++) begin
                    if (ab_sync[i] == filt[i]) begin
                        deb_cnt_next[i] = '0;
                    end else if (deb_cnt[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                        filt_next[i]    = ab_sync[i];
                        deb_cnt_next[i] = '0;
                    end else begin
                        deb_cnt_next[i] = deb_cnt[i] + DEB_W'(1);
                    end
                end

                sub_delta = (move == MV_BACK) ? '1 : SUB_W'(1);
                sub_sum   = sub_cnt + sub_delta;

                if (move == MV_ILLEGAL) begin
                    err_next     = 1'b1;
                    sub_cnt_next = '0;
                end else if (move != MV_NONE) begin
                    if (sub_sum == SUB_MAX) begin
                        step_next     = 1'b1;
                        dir_next      = 1'b1;
                        position_next = position + CNT_WIDTH'(1);
                        sub_cnt_next  = '0;
                    end else if (sub_sum == SUB_MIN) begin
                        step_next     = 1'b1;
                        dir_next      = 1'b0;
                        position_next = position - CNT_WIDTH'(1);
                        sub_cnt_next  = '0;
                    end else begin
                        sub_cnt_next = sub_sum;
                    end
                end

                // Clear overrides anything decoded this cycle, including a completing step.
                if (bus.clear) begin
                    position_next = '0;
                    err_next      = 1'b0;
                    sub_cnt_next  = '0;
                    step_next     = 1'b0;
                    dir_next      = dir;
                end
            end

            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            filt       <= '0;
            filt_prev  <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
            sub_cnt    <= '0;
            position   <= '0;
            dir        <= 1'b0;
            err        <= 1'b0;
            step       <= 1'b0;
            ready      <= 1'b0;
        end else begin
            state      <= state_next;
            init_cnt   <= init_cnt_next;
            filt       <= filt_next;
            filt_prev  <= filt_prev_next;
            deb_cnt[0] <= deb_cnt_next[0];
            deb_cnt[1] <= deb_cnt_next[1];
            sub_cnt    <= sub_cnt_next;
            position   <= position_next;
            dir        <= dir_next;
            err        <= err_next;
            step       <= step_next;
            ready      <= ready_next;
        end
    end

    assign bus.ready    = ready;
    assign bus.step     = step;
    assign bus.dir      = dir;
    assign bus.position = position;
    assign bus.err      = err;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed and random phase sequences, with step/err
// events predicted from the quadrature rules and matched by an independent monitor.
module tb_quad_step_decoder;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int SPD  = 4;
    localparam int CW   = 8;
    localparam int HOLD = 10;

    typedef struct {
        bit             isStep;
        bit             dir;
        logic [CW-1:0]  pos;
    } expect_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    quad_step_decoder_if #(.CNT_WIDTH(CW)) bus ();

    quad_step_decoder #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .STEPS_PER_DETENT(SPD),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    expect_t       expq[$];
    int            checks   = 0;
    int            failures = 0;
    logic [1:0]    mAb;
    int            mSub;
    logic [CW-1:0] mPos;
    bit            mDir;
    bit            mErr;
    int            grayOrder[4] = '{0, 1, 3, 2};
    bit            stepPrev = 1'b0;
    bit            errPrev  = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    function automatic int gidx(input logic [1:0] ab);
        int r = 0;
        for (int i = 0; i < 4; i++)
            if (grayOrder[i] == int'(ab)) r = i;
        return r;
    endfunction

    // Reference: position along the 4-state Gray cycle determines the move.
    task automatic applyStimulus(input logic [1:0] ab);
        int d;
        expect_t e;
        d = (gidx(ab) - gidx(mAb) + 4) % 4;
        if (d == 1) mSub++;
        else if (d == 3) mSub--;
        else if (d == 2) begin
            if (!mErr) begin
                e.isStep = 1'b0; e.dir = mDir; e.pos = mPos;
                expq.push_back(e);
            end
            mErr = 1'b1;
            mSub = 0;
        end
        if (mSub == SPD) begin
            mPos++; mDir = 1'b1; mSub = 0;
            e.isStep = 1'b1; e.dir = mDir; e.pos = mPos;
            expq.push_back(e);
        end else if (mSub == -SPD) begin
            mPos--; mDir = 1'b0; mSub = 0;
            e.isStep = 1'b1; e.dir = mDir; e.pos = mPos;
            expq.push_back(e);
        end
        mAb = ab;
        bus.encoder_a = ab[1];
        bus.encoder_b = ab[0];
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic doClear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        mPos = '0; mErr = 1'b0; mSub = 0;
        checkOutput("clear_position", bus.position, 0);
        checkOutput("clear_err", bus.err, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic doGlitch(input int phase, input int len);
        if (phase == 1) bus.encoder_a = ~mAb[1];
        else            bus.encoder_b = ~mAb[0];
        repeat (len) @(negedge clk);
        bus.encoder_a = mAb[1];
        bus.encoder_b = mAb[0];
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic initAfterReset();
        int lat = -1;
        bit noisy = 1'b0;
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.step || bus.err) noisy = 1'b1;
            if (bus.ready) begin
                lat = k;
                break;
            end
        end
        checkOutput("init_ready_latency", lat, SYNC + DEB);
        checkOutput("init_step_or_err_seen", noisy, 0);
        checkOutput("init_position", bus.position, 0);
        mSub = 0; mPos = '0; mDir = 1'b0; mErr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cwDetent();
        applyStimulus(2'b01); applyStimulus(2'b11);
        applyStimulus(2'b10); applyStimulus(2'b00);
    endtask

    task automatic ccwDetent();
        applyStimulus(2'b10); applyStimulus(2'b11);
        applyStimulus(2'b01); applyStimulus(2'b00);
    endtask

    // Monitor: every step pulse or err rise must match the next predicted event.
    always @(negedge clk) begin
        expect_t e;
        if (bus.step) begin
            if (stepPrev) checkOutput("step_back_to_back", 1, 0);
            if (expq.size() == 0) begin
                checkOutput("unexpected_step_pos", bus.position, 32'hFFFF_FFFF);
            end else begin
                e = expq.pop_front();
                checkOutput("event_is_step", 1, e.isStep);
                checkOutput("step_dir", bus.dir, e.dir);
                checkOutput("step_position", bus.position, e.pos);
            end
        end
        if (bus.err && !errPrev) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_err_pos", bus.position, 32'hFFFF_FFFF);
            end else begin
                e = expq.pop_front();
                checkOutput("event_is_err", 0, e.isStep);
                checkOutput("err_position", bus.position, e.pos);
            end
        end
        stepPrev = bus.step;
        errPrev  = bus.err;
    end

    initial begin
        int bias;
        int r;
        int idx;
        bus.encoder_a = 1'b1;
        bus.encoder_b = 1'b1;
        bus.clear     = 1'b0;
        mAb           = 2'b11;
        #12;
        checkOutput("reset_ready", bus.ready, 0);
        checkOutput("reset_step", bus.step, 0);
        checkOutput("reset_dir", bus.dir, 0);
        checkOutput("reset_position", bus.position, 0);
        checkOutput("reset_err", bus.err, 0);
        @(negedge clk);
        initAfterReset();

        applyStimulus(2'b10);
        applyStimulus(2'b00);
        doClear();

        cwDetent();
        checkOutput("cw1_position", bus.position, 8'h01);
        checkOutput("cw1_dir", bus.dir, 1);
        cwDetent();
        checkOutput("cw2_position", bus.position, 8'h02);

        doClear();
        ccwDetent();
        checkOutput("ccw_wrap_position", bus.position, 8'hFF);
        checkOutput("ccw_dir", bus.dir, 0);
        cwDetent();
        checkOutput("cw_wrap_position", bus.position, 8'h00);
        ccwDetent();
        checkOutput("ccw_wrap2_position", bus.position, 8'hFF);

        doGlitch(1, 3);
        doGlitch(0, 3);
        checkOutput("glitch_position", bus.position, 8'hFF);
        checkOutput("glitch_err", bus.err, 0);

        applyStimulus(2'b11);
        checkOutput("illegal_err", bus.err, 1);
        checkOutput("illegal_position", bus.position, 8'hFF);
        applyStimulus(2'b01); applyStimulus(2'b11);
        applyStimulus(2'b10); applyStimulus(2'b00);
        checkOutput("after_illegal_position", bus.position, 8'hFF);
        doClear();

        applyStimulus(2'b01); applyStimulus(2'b11);
        applyStimulus(2'b01); applyStimulus(2'b00);
        checkOutput("partial_position", bus.position, 8'h00);

        bias = 80;
        for (int n = 0; n < 200; n++) begin
            if (n % 50 == 0) bias = 100 - bias;
            r   = $urandom_range(0, 99);
            idx = gidx(mAb);
            if (r < 75) begin
                if ($urandom_range(0, 99) < bias) applyStimulus(2'(grayOrder[(idx + 1) % 4]));
                else                              applyStimulus(2'(grayOrder[(idx + 3) % 4]));
            end else if (r < 85) begin
                applyStimulus(2'(grayOrder[(idx + 2) % 4]));
            end else if (r < 95) begin
                doGlitch($urandom_range(0, 1), $urandom_range(1, 3));
            end else begin
                doClear();
            end
            checkOutput("random_position", bus.position, mPos);
            checkOutput("random_err", bus.err, mErr);
        end

        doClear();
        applyStimulus(2'(grayOrder[(gidx(mAb) + 1) % 4]));
        while (mAb != 2'b00) applyStimulus(2'(grayOrder[(gidx(mAb) + 1) % 4]));
        doClear();
        cwDetent();
        checkOutput("pre_reset_position", bus.position, 8'h01);

        bus.encoder_b = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midreset_ready", bus.ready, 0);
        checkOutput("midreset_step", bus.step, 0);
        checkOutput("midreset_dir", bus.dir, 0);
        checkOutput("midreset_position", bus.position, 0);
        checkOutput("midreset_err", bus.err, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("held_reset_ready", bus.ready, 0);
        mAb = 2'b01;
        initAfterReset();
        applyStimulus(2'b11); applyStimulus(2'b10);
        applyStimulus(2'b00); applyStimulus(2'b01);
        checkOutput("post_reset_position", bus.position, 8'h01);
        checkOutput("post_reset_dir", bus.dir, 1);

        repeat (HOLD) @(negedge clk);
        checkOutput("events_pending", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quad_step_decoder.md
# quad_step_decoder

Conditions the raw quadrature inputs from the rotary encoder (`encoder_a`, `encoder_b`) and turns them into clean detent steps. Each phase is synchronised and debounced, then Gray-code transitions are decoded into direction-tagged step pulses and a wrapping position count. The block sits directly upstream of the encoder-to-colour stage and feeds it `step`, `dir` and `position`. The Wishbone control block reads `position` and `err` as status.

## Interface
- `SYNC_STAGES`, 2: flip-flop synchroniser depth per phase (≥2).
- `DEBOUNCE_CYCLES`, 1000: consecutive clk cycles a synchronised phase must differ from its filtered value before the filtered value updates (≥1).
- `STEPS_PER_DETENT`, 4: valid transitions per reported step (power of 2, 1..8).
- `CNT_WIDTH`, 8: width of `position`.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `encoder_a`  in  1  raw phase A, asynchronous to clk.
- `encoder_b`  in  1  raw phase B, asynchronous to clk.
- `clear`  in  1  synchronous clear of `position`, `err` and the sub-count.
- `ready`  out  1  high once the initial filtered state is captured.
- `step`  out  1  one-cycle pulse per completed detent.
- `dir`  out  1  direction of the last step: 1 = CW, 0 = CCW; held between steps.
- `position`  out  CNT_WIDTH  signed detent count, modulo 2^CNT_WIDTH.
- `err`  out  1  sticky flag for an illegal transition (both phases changed).

## Operation
- **Reset values** (`rst` low, asynchronous): `ready`=0, `step`=0, `dir`=0, `position`=0, `err`=0.
  - Also cleared: sub-count, debounce counters, synchroniser chain, filtered state (00).
  - FSM enters INIT.
- **FSM INIT**
  - Runs for SYNC_STAGES+DEBOUNCE_CYCLES cycles after reset release.
  - On exit, loads filtered AB = synchronised AB with no decode, so no spurious step or `err`.
  - Moves to RUN and sets `ready`=1.
- **FSM RUN**
  - **Debounce, per phase:** the counter increments while synchronised ≠ filtered and resets to 0 when they are equal. When the counter reaches DEBOUNCE_CYCLES, the filtered bit takes the synchronised value and the counter returns to 0.
  - **Decode:** compare the previous filtered AB with the new filtered AB each cycle.
    - 00→01→11→10→00: +1 to the sub-count.
    - Reverse order: −1 to the sub-count.
    - Unchanged: no action.
    - Both bits changed: `err`←1, sub-count←0, `position` unchanged, no step.
  - **Sub-count:** signed range ±STEPS_PER_DETENT.
    - Reaches +STEPS_PER_DETENT: `step`=1, `dir`=1, `position`+1, sub-count←0.
    - Reaches −STEPS_PER_DETENT: `step`=1, `dir`=0, `position`−1, sub-count←0.
    - Direction reversal mid-detent simply counts back; no step is emitted.
- **Arithmetic:** `position` wraps in both directions (0xFF+1 = 0x00, 0x00−1 = 0xFF for CNT_WIDTH=8).
- **`clear`:**
  - Zeroes `position`, `err` and the sub-count; `dir` is kept.
  - Wins over a step or error decoded in the same cycle; that step is discarded and `step` stays 0.
  - Ignored in INIT.
- **Independence:** the two phases' debounce counters run independently. Updates on both phases in the same cycle count as a double change and raise `err`.

## Timing
- Fully synchronous to `clk` except `rst`. All outputs are registered.
- Raw edge to filtered update: SYNC_STAGES+DEBOUNCE_CYCLES cycles of stable input.
- Filtered update to `step` / `position` update: 1 cycle. `step` and the new `position` appear on the same cycle.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no filtered change.
- `step` is never high on two consecutive cycles.
- `ready` rises exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles after `rst` deasserts and stays high until the next reset.
- Reset asserted mid-detent or mid-debounce discards all partial state immediately.

## Test plan
Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STEPS_PER_DETENT=4, CNT_WIDTH=8. Each phase state is held 10 cycles unless noted.

- **Init:** release `rst` with A=B=1 → `ready` rises after 6 cycles; `step`=0 and `err`=0 throughout; `position`=0x00.
- **CW detent:** AB 00→01→11→10→00 → exactly one `step` pulse with `dir`=1, `position`=0x01. A second detent → `position`=0x02.
- **CCW wrap:** from `position`=0x00, AB 00→10→11→01→00 → one `step` pulse with `dir`=0, `position`=0xFF.
- **Glitch rejection:** A pulsed high for 3 cycles, then B for 3 cycles → filtered AB unchanged, no `step`, no `err`.
- **Illegal transition:** AB 00→11 in one cycle → `err`=1, `position` unchanged.
  - Then 01→11→10→00 → no `step` (sub-count was reset).
  - Then `clear` → `err`=0, `position`=0x00.
- **Partial detent and reset:**
  - AB 00→01→11→01→00 → no `step`, `position` unchanged.
  - Assert `rst` mid-debounce → all outputs at reset values within the same cycle; `ready`=0 until re-init completes.
